// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one alu_16 between two requesters.
// One operation in flight; FSM IDLE -> ISSUE -> WAIT -> RESP.
// Optional build macro ARB_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT_CYCLES.
module alu_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [2:0]  op0,
    input  logic [2:0]  op1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        alu_start,
    output logic [2:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic        alu_done
);

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic            rv0_q, rv0_d, rv1_q, rv1_d;
    logic            start_q, start_d;
    logic            win_q, win_d;
    logic            last_q, last_d;
    logic            win_sel_c;
    logic            timeout_c;

    // Round-robin pick: a tie goes to the requester not granted last.
    assign win_sel_c = (req0 & req1) ? ~last_q : req1;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // WAIT-cycle counter; held at zero outside WAIT so it clears on entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout_c  = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rv0_q      <= 1'b0;
            rv1_q      <= 1'b0;
            start_q    <= 1'b0;
            win_q      <= 1'b0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rv0_q      <= rv0_d;
            rv1_q      <= rv1_d;
            start_q    <= start_d;
            win_q      <= win_d;
            last_q     <= last_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req0 | req1) state_d = S_ISSUE;
            S_ISSUE: state_d = op_q[2] ? S_RESP : S_WAIT;
            S_WAIT:  if (alu_done | timeout_c) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; pulses are loaded one edge ahead of their state.
    always_comb begin
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rv0_d      = 1'b0;
        rv1_d      = 1'b0;
        start_d    = 1'b0;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        win_d      = win_q;
        last_d     = last_q;
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    win_d   = win_sel_c;
                    last_d  = win_sel_c;
                    op_d    = win_sel_c ? op1 : op0;
                    a_d     = win_sel_c ? a1  : a0;
                    b_d     = win_sel_c ? b1  : b0;
                    gnt0_d  = ~win_sel_c;
                    gnt1_d  = win_sel_c;
                    start_d = ~op_d[2];
                end
            end
            S_ISSUE: begin
                if (op_q[2]) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    rv0_d      = ~win_q;
                    rv1_d      = win_q;
                end
            end
            S_WAIT: begin
                if (alu_done) begin
                    rsp_data_d = alu_result;
                    rsp_err_d  = 1'b0;
                    rv0_d      = ~win_q;
                    rv1_d      = win_q;
                end else if (timeout_c) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    rv0_d      = ~win_q;
                    rv1_d      = win_q;
                end
            end
            default: ;
        endcase
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign rsp_valid0 = rv0_q;
    assign rsp_valid1 = rv1_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign alu_start  = start_q;
    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural alu_16 stub.
module tb_alu_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_TO = 8;
`else
    localparam int unsigned TB_TO = 64;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [2:0]  op0 = '0, op1 = '0;
    logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, alu_start;
    logic [15:0] rsp_data, alu_a, alu_b;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_result = '0;
    logic        alu_done = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_g0 = 0, n_g1 = 0, n_v0 = 0, n_v1 = 0;

    alu_arbiter #(.TIMEOUT_CYCLES(TB_TO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_opcode(alu_opcode),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_done(alu_done)
    );

    always #5 clk = ~clk;

    // Cycle counter and pulse counters (values seen during the cycle just ended).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gnt0)       n_g0 <= n_g0 + 1;
        if (gnt1)       n_g1 <= n_g1 + 1;
        if (rsp_valid0) n_v0 <= n_v0 + 1;
        if (rsp_valid1) n_v1 <= n_v1 + 1;
    end

    // alu_16 stub: done clears on start, rises stub_lat cycles later and holds.
    bit          stub_en = 1'b1;
    int          stub_lat = 2;
    int          stub_cnt = 0;
    logic        stub_busy = 1'b0;
    logic [15:0] stub_res = '0;

    function automatic logic [15:0] stub_calc(input logic [2:0] op,
                                              input logic signed [15:0] a,
                                              input logic signed [15:0] b);
        logic signed [31:0] p;
        p = a * b;
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return p[15:0];
            3'b011:  return (b == 0) ? 16'd0 : 16'(a / b);
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_start) begin
            alu_done  <= 1'b0;
            stub_busy <= 1'b1;
            stub_cnt  <= stub_lat;
            stub_res  <= stub_calc(alu_opcode, alu_a, alu_b);
        end else if (stub_busy) begin
            if (stub_cnt <= 1) begin
                if (stub_en) begin
                    alu_done   <= 1'b1;
                    alu_result <= stub_res;
                    stub_busy  <= 1'b0;
                end
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, rsp_valid0, rsp_valid1} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_pulses: got %b expected 0000", {gnt0, gnt1, rsp_valid0, rsp_valid1});
        end
        n_checks++;
        if ({rsp_err, rsp_data} !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_rsp: got err=%b data=%h expected 0/0000", rsp_err, rsp_data);
        end
        n_checks++;
        if ({alu_start, alu_opcode, alu_a, alu_b} !== 36'd0) begin
            n_errors++;
            $display("FAIL reset_alu: got start=%b op=%b a=%h b=%h expected zeros", alu_start, alu_opcode, alu_a, alu_b);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int g_cyc, s_g0, s_g1, s_v0, s_v1;
        bit seen;
        s_g0 = n_g0; s_g1 = n_g1; s_v0 = n_v0; s_v1 = n_v1;
        req0 = 1'b1; op0 = 3'b000; a0 = 16'd100; b0 = -16'sd30;
        @(negedge clk);
        g_cyc = cyc;
        n_checks++;
        if ({gnt0, gnt1, alu_start, alu_opcode, alu_a, alu_b} !== {3'b101, 3'b000, 16'd100, 16'hFFE2}) begin
            n_errors++;
            $display("FAIL single_issue: got gnt0=%b gnt1=%b start=%b op=%b a=%h b=%h expected 1 0 1 000 0064 ffe2",
                     gnt0, gnt1, alu_start, alu_opcode, alu_a, alu_b);
        end
        req0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid0) seen = 1'b1;
        end
        n_checks++;
        if (!seen || (cyc - g_cyc) != 4) begin
            n_errors++;
            $display("FAIL single_latency: got seen=%b delay=%0d expected 1 and 4", seen, cyc - g_cyc);
        end
        n_checks++;
        if (rsp_data !== 16'd70 || rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL single_data: got data=%0d err=%b expected 70 0", $signed(rsp_data), rsp_err);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ((n_g0 - s_g0) != 1 || (n_v0 - s_v0) != 1 || n_g1 != s_g1 || n_v1 != s_v1) begin
            n_errors++;
            $display("FAIL single_counts: got g0=%0d v0=%0d g1=%0d v1=%0d expected 1 1 0 0",
                     n_g0 - s_g0, n_v0 - s_v0, n_g1 - s_g1, n_v1 - s_v1);
        end
        n_checks++;
        if (rsp_data !== 16'd70) begin
            n_errors++;
            $display("FAIL single_hold: got data=%h expected 0046", rsp_data);
        end
    endtask

    task automatic test_tie();
        int          rid[2];
        logic [15:0] rdat[2];
        int          nr, s_g0, s_g1, s_v0, s_v1;
        do_reset();
        s_g0 = n_g0; s_g1 = n_g1; s_v0 = n_v0; s_v1 = n_v1;
        nr = 0;
        rid[0] = -1; rid[1] = -1; rdat[0] = '0; rdat[1] = '0;
        req0 = 1'b1; op0 = 3'b010; a0 = -16'sd7;   b0 = 16'd9;
        req1 = 1'b1; op1 = 3'b011; a1 = 16'd1000; b1 = 16'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
            if ((rsp_valid0 || rsp_valid1) && nr < 2) begin
                rid[nr]  = rsp_valid1 ? 1 : 0;
                rdat[nr] = rsp_data;
                nr++;
            end
        end
        n_checks++;
        if (rid[0] != 0 || rdat[0] !== -16'sd63) begin
            n_errors++;
            $display("FAIL tie_first: got id=%0d data=%0d expected 0 -63", rid[0], $signed(rdat[0]));
        end
        n_checks++;
        if (rid[1] != 1 || rdat[1] !== 16'd0) begin
            n_errors++;
            $display("FAIL tie_second: got id=%0d data=%0d expected 1 0", rid[1], $signed(rdat[1]));
        end
        n_checks++;
        if ((n_g0 - s_g0) != 1 || (n_g1 - s_g1) != 1 || (n_v0 - s_v0) != 1 || (n_v1 - s_v1) != 1) begin
            n_errors++;
            $display("FAIL tie_counts: got g0=%0d g1=%0d v0=%0d v1=%0d expected 1 1 1 1",
                     n_g0 - s_g0, n_g1 - s_g1, n_v0 - s_v0, n_v1 - s_v1);
        end
    endtask

    task automatic test_alternate();
        int gseq[6];
        int ng;
        do_reset();
        ng = 0;
        for (int k = 0; k < 6; k++) gseq[k] = -1;
        req0 = 1'b1; op0 = 3'b000; a0 = 16'd1;  b0 = 16'd2;
        req1 = 1'b1; op1 = 3'b001; a1 = 16'd10; b1 = 16'd4;
        for (int i = 0; i < 200 && ng < 6; i++) begin
            @(negedge clk);
            if (gnt0 && ng < 6) begin gseq[ng] = 0; ng++; end
            if (gnt1 && ng < 6) begin gseq[ng] = 1; ng++; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (gseq[k] != (k % 2)) begin
                n_errors++;
                $display("FAIL alt_grant%0d: got %0d expected %0d", k, gseq[k], k % 2);
            end
        end
    endtask

    task automatic test_illegal();
        int s_v0;
        s_v0 = n_v0;
        req1 = 1'b1; op1 = 3'b101; a1 = 16'd5; b1 = 16'd6;
        @(negedge clk);
        n_checks++;
        if (gnt1 !== 1'b1 || alu_start !== 1'b0 || gnt0 !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_issue: got gnt1=%b start=%b gnt0=%b expected 1 0 0", gnt1, alu_start, gnt0);
        end
        req1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid1 !== 1'b1 || rsp_data !== 16'd0 || rsp_err !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_rsp: got valid1=%b data=%h err=%b expected 1 0000 1", rsp_valid1, rsp_data, rsp_err);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_v0 != s_v0 || rsp_err !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_after: got v0=%0d err=%b expected 0 1", n_v0 - s_v0, rsp_err);
        end
    endtask

    task automatic test_reset_mid();
        int  s_v0, s_v1;
        bit  seen;
        stub_lat = 6;
        req0 = 1'b1; op0 = 3'b010; a0 = 16'd3; b0 = 16'd4;
        @(negedge clk);
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_grant: got gnt0=%b expected 1", gnt0);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, alu_start, rsp_data, alu_opcode, alu_a, alu_b} !== 57'd0) begin
            n_errors++;
            $display("FAIL mid_reset_zero: got g=%b%b v=%b%b err=%b start=%b data=%h op=%b a=%h b=%h expected zeros",
                     gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, alu_start, rsp_data, alu_opcode, alu_a, alu_b);
        end
        s_v0 = n_v0; s_v1 = n_v1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (n_v0 != s_v0 || n_v1 != s_v1) begin
            n_errors++;
            $display("FAIL mid_no_rsp: got v0=%0d v1=%0d expected 0 0", n_v0 - s_v0, n_v1 - s_v1);
        end
        stub_lat = 2;
        req1 = 1'b1; op1 = 3'b000; a1 = -16'sd5; b1 = 16'd2;
        @(negedge clk);
        req1 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || rsp_data !== -16'sd3 || rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_next_op: got seen=%b data=%0d err=%b expected 1 -3 0", seen, $signed(rsp_data), rsp_err);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int g_cyc;
        bit seen;
        stub_en = 1'b0;
        req0 = 1'b1; op0 = 3'b000; a0 = 16'd1; b0 = 16'd1;
        @(negedge clk);
        g_cyc = cyc;
        req0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid0) seen = 1'b1;
        end
        n_checks++;
        if (!seen || (cyc - g_cyc) != 9 || rsp_err !== 1'b1 || rsp_data !== 16'd0) begin
            n_errors++;
            $display("FAIL timeout_abort: got seen=%b delay=%0d err=%b data=%h expected 1 9 1 0000",
                     seen, cyc - g_cyc, rsp_err, rsp_data);
        end
        stub_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_illegal();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
